// File: rtl/lc3_uart_mmio_ctrl.sv
// LC-3 keyboard/display MMIO controller: KBSR/KBDR/DSR/DDR decode, RX FIFO,
// TX holding register and level interrupt request.
module lc3_uart_mmio_ctrl #(
    parameter int          RX_DEPTH  = 4,
    parameter int          UART_W    = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              mem_wen,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_rdata_valid,
    output logic [UART_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [UART_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              irq
);
    localparam int AW  = $clog2(RX_DEPTH);
    localparam int CW  = AW + 1;
    localparam int PAD = 16 - UART_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);
    localparam logic [15:0] KBSR_A = BASE_ADDR;
    localparam logic [15:0] KBDR_A = BASE_ADDR + 16'd2;
    localparam logic [15:0] DSR_A  = BASE_ADDR + 16'd4;
    localparam logic [15:0] DDR_A  = BASE_ADDR + 16'd6;

    logic [UART_W-1:0] fifoMem [RX_DEPTH];
    logic [AW-1:0]     wrPtr, rdPtr;
    logic [CW-1:0]     count;
    logic              txFull, kie, die, ovr;

    logic isKbsr, isKbdr, isDsr, isDdr, mapped;
    logic rdEn, wrEn, empty, full, push, pop, txFire, ddrWr, ddrLoad;
    logic [UART_W-1:0] rxHead;

    assign isKbsr = (mem_addr == KBSR_A);
    assign isKbdr = (mem_addr == KBDR_A);
    assign isDsr  = (mem_addr == DSR_A);
    assign isDdr  = (mem_addr == DDR_A);
    assign mapped = isKbsr | isKbdr | isDsr | isDdr;
    assign rdEn   = mem_en & ~mem_wen;
    assign wrEn   = mem_en & mem_wen;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign rxHead = fifoMem[rdPtr];
    // Ready follows the registered count only, so a same-cycle pop never frees a slot early.
    assign rx_ready = ~full;
    assign push     = rx_valid & ~full;
    assign pop      = rdEn & isKbdr & ~empty;

    assign tx_valid = txFull;
    assign txFire   = txFull & tx_ready;
    assign ddrWr    = wrEn & isDdr;
    assign ddrLoad  = ddrWr & (~txFull | txFire);

    assign irq = (kie & ~empty) | (die & ~txFull);

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr           <= '0;
            rdPtr           <= '0;
            count           <= '0;
            txFull          <= 1'b0;
            tx_data         <= '0;
            kie             <= 1'b0;
            die             <= 1'b0;
            ovr             <= 1'b0;
            mem_rdata       <= '0;
            mem_rdata_valid <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (ddrLoad) begin
                tx_data <= mem_wdata[UART_W-1:0];
                txFull  <= 1'b1;
            end else if (txFire) begin
                txFull  <= 1'b0;
            end

            if (wrEn && isKbsr) kie <= mem_wdata[14];
            if (wrEn && isDsr) begin
                die <= mem_wdata[14];
                if (mem_wdata[0]) ovr <= 1'b0;
            end
            if (ddrWr && !ddrLoad) ovr <= 1'b1;

            mem_rdata_valid <= rdEn & mapped;
            if (rdEn && mapped) begin
                if (isKbsr)      mem_rdata <= {~empty, kie, 14'b0};
                else if (isKbdr) mem_rdata <= empty ? 16'h0000 : {{PAD{1'b0}}, rxHead};
                else if (isDsr)  mem_rdata <= {~txFull, die, 13'b0, ovr};
                else             mem_rdata <= {{PAD{1'b0}}, tx_data};
            end
        end
    end
endmodule

// File: tb/tb_lc3_uart_mmio_ctrl.sv
// Directed bench for lc3_uart_mmio_ctrl: bus reads and TX bytes are checked
// against expected values queued when the stimulus is issued.
module tb_lc3_uart_mmio_ctrl;
    logic        clk;
    logic        rst_n;
    logic        mem_en, mem_wen;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rdata_valid;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int checks = 0;
    int failures = 0;
    int txSeen = 0;
    logic [15:0] rdQ[$];
    logic [7:0]  txQ[$];

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;

    lc3_uart_mmio_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busRead(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] e;
        rdQ.push_back(exp);
        mem_en = 1'b1; mem_wen = 1'b0; mem_addr = addr;
        tick();
        mem_en = 1'b0;
        chk({tag, "_vld"}, mem_rdata_valid, 1);
        chk({tag, "_qlen"}, rdQ.size(), 1);
        if (rdQ.size() > 0) begin
            e = rdQ.pop_front();
            chk(tag, mem_rdata, e);
        end
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        mem_en = 1'b1; mem_wen = 1'b1; mem_addr = addr; mem_wdata = data;
        tick();
        mem_en = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic rxPush(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // TX scoreboard: every completed handshake must match the next queued byte.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            txSeen++;
            chk("tx_q_nonempty", txQ.size() > 0, 1);
            if (txQ.size() > 0) chk("tx_byte", tx_data, txQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bytes [5];
        bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        rst_n = 1'b1; mem_en = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_rdata", mem_rdata, 16'h0000);
        chk("rst_rvld", mem_rdata_valid, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_irq", irq, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        busRead("kbsr_rst", KBSR, 16'h0000);
        busRead("dsr_rst", DSR, 16'h8000);
        mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 16'hFE08;
        tick();
        mem_en = 1'b0;
        chk("unmapped_vld", mem_rdata_valid, 0);
        chk("unmapped_hold", mem_rdata, 16'h8000);

        rxPush(8'h41);
        rxPush(8'h42);
        busRead("kbsr_ne", KBSR, 16'h8000);
        busRead("kbdr_41", KBDR, 16'h0041);
        busRead("kbdr_42", KBDR, 16'h0042);
        busRead("kbdr_empty", KBDR, 16'h0000);
        busRead("kbsr_empty", KBSR, 16'h0000);

        // Fill across the pointer wrap, then hold a fifth byte until a pop.
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = bytes[i];
            chk("fill_ready", rx_ready, 1);
            tick();
        end
        chk("full_ready", rx_ready, 0);
        rx_data = bytes[4];
        tick();
        chk("full_hold_ready", rx_ready, 0);
        busRead("kbdr_a0", KBDR, 16'h00A0);
        chk("ready_after_pop", rx_ready, 1);
        tick();
        rx_valid = 1'b0;
        chk("refull_ready", rx_ready, 0);
        for (int i = 1; i < 5; i++) busRead("kbdr_wrap", KBDR, {8'h00, bytes[i]});
        busRead("kbsr_drained", KBSR, 16'h0000);

        txQ.push_back(8'h55);
        busWrite(DDR, 16'h0055);
        chk("tx_valid_55", tx_valid, 1);
        busWrite(DDR, 16'h0066);
        chk("tx_data_held", tx_data, 8'h55);
        chk("tx_valid_held", tx_valid, 1);
        busRead("dsr_ovr_full", DSR, 16'h0001);
        busRead("ddr_read", DDR, 16'h0055);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("tx_done", tx_valid, 0);
        busRead("dsr_ovr_empty", DSR, 16'h8001);
        busWrite(DSR, 16'h0001);
        busRead("dsr_clr", DSR, 16'h8000);

        tx_ready = 1'b1;
        txQ.push_back(8'h10);
        txQ.push_back(8'h11);
        busWrite(DDR, 16'h0010);
        chk("b2b_v0", tx_valid, 1);
        chk("b2b_d0", tx_data, 8'h10);
        busWrite(DDR, 16'h0011);
        chk("b2b_v1", tx_valid, 1);
        chk("b2b_d1", tx_data, 8'h11);
        tick();
        chk("b2b_done", tx_valid, 0);
        tx_ready = 1'b0;
        busRead("dsr_no_ovr", DSR, 16'h8000);

        busWrite(KBSR, 16'h4000);
        chk("irq_kie_empty", irq, 0);
        rxPush(8'h77);
        chk("irq_kie_data", irq, 1);
        busRead("kbdr_77", KBDR, 16'h0077);
        chk("irq_kie_popped", irq, 0);
        busWrite(DSR, 16'h4000);
        chk("irq_die", irq, 1);
        busWrite(DSR, 16'h0000);
        chk("irq_die_off", irq, 0);

        busWrite(DDR, 16'h0099);
        rxPush(8'h33);
        chk("pre_rst_tx_valid", tx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_irq", irq, 0);
        tick();
        rst_n = 1'b1;
        tick();
        busRead("kbsr_after_rst", KBSR, 16'h0000);
        busRead("dsr_after_rst", DSR, 16'h8000);

        chk("txq_drained", txQ.size(), 0);
        chk("tx_handshakes", txSeen, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
